stopwatch_ctrl: RTL
===================

# stopwatch_ctrl

Sequencing controller for the stopwatch digit-counter chain. It turns two debounced push-buttons into run, pause, lap and clear commands. It generates the base 1/100 s count tick that drives the hundredths digit, and it captures a lap snapshot of the four BCD digits for the display mux. It sits between the button debouncers and the cascaded digit counters and display.

## Interface
Parameters:
- TICK_DIV, 1000000: clk cycles per count tick (100 MHz clock gives 10 ms).
- DIV_W, 20: prescaler width; must satisfy 2^DIV_W >= TICK_DIV.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- btn_ss  in  1  debounced start/stop level, asynchronous to clk.
- btn_lr  in  1  debounced lap/reset level, asynchronous to clk.
- time_bcd  in  16  live digits from the counter chain, {tens_s, s, ts, hs}, 4 bits each.
- at_max  in  1  high when the chain reads 99.99 s.
- tick  out  1  one-cycle count enable to the hundredths counter.
- count_clear  out  1  one-cycle synchronous clear to every digit counter.
- display_freeze  out  1  high means the display shows lap_bcd instead of time_bcd.
- lap_bcd  out  16  latched lap snapshot.
- state  out  2  current FSM state encoding.

## Operation
- Input conditioning:
  - Each button passes through a 2-FF synchronizer, then a rising-edge detector.
  - An action is therefore a 1-cycle pulse (ss_p, lr_p).
  - Held buttons produce exactly one pulse.
- FSM states: IDLE=00, RUN=01, LAP=10, PAUSE=11.
- Transitions:
  - IDLE: ss_p -> RUN. lr_p is ignored.
  - RUN: ss_p -> PAUSE. lr_p -> LAP, and lap_bcd <= time_bcd in the same cycle.
  - LAP (counting continues, display frozen):
    - ss_p -> PAUSE; freeze is released.
    - lr_p -> RUN; freeze is released.
  - PAUSE:
    - ss_p -> RUN; the prescaler resumes from its held value.
    - lr_p -> IDLE; count_clear pulses, prescaler <= 0, lap_bcd <= 0.
- Simultaneous ss_p and lr_p in the same cycle: ss_p wins and lr_p is discarded.
- Prescaler:
  - Increments only in RUN or LAP.
  - At TICK_DIV-1 it wraps to 0 and tick = 1 for that cycle.
  - Holds its value in PAUSE and IDLE.
- Saturation:
  - If a tick would fire while at_max = 1, tick is suppressed.
  - The FSM goes to PAUSE, with display_freeze = 0 from the next cycle.
  - The chain therefore never wraps 99.99 -> 00.00.
  - An ss_p in PAUSE while at_max = 1 is ignored; only lr_p (clear) leaves that state.
- display_freeze = 1 exactly when state == LAP (registered).
- count_clear is asserted only on the PAUSE -> IDLE transition. It is never asserted during reset; the chain has its own reset.

## Timing
- Reset values (rst = 0, asynchronous): state = IDLE, tick = 0, count_clear = 0, display_freeze = 0, lap_bcd = 0, prescaler = 0, synchronizer and edge flops = 0.
- Button latency:
  - A rise on btn_* sampled at edge N gives the pulse at edge N+2.
  - The state changes at edge N+3, together with the registered outputs for that transition (count_clear, lap_bcd).
- First tick after IDLE -> RUN: exactly TICK_DIV cycles after the state becomes RUN. Later ticks follow every TICK_DIV cycles.
- Pause and resume: the cycles counted before PAUSE are preserved. Total RUN/LAP cycles between consecutive ticks always equals TICK_DIV.
- tick and count_clear are registered outputs, never asserted in the same cycle.
- A tick in the same cycle as an lr_p that causes RUN -> LAP is still delivered. lap_bcd captures the pre-tick time_bcd.
- Reset asserted mid-run:
  - All outputs return to reset values immediately.
  - After release, the FSM waits in IDLE; stale button levels do not generate pulses until they fall and rise again.

## Test plan
All scenarios use TICK_DIV = 4.
1. Reset, then pulse btn_ss -> state goes 00 -> 01 three cycles after the button rise. tick fires every 4th cycle; 10 ticks are observed in 40 cycles.
2. RUN for 6 cycles (prescaler = 2), then btn_ss to pause for 20 cycles, then btn_ss again -> no tick during PAUSE. The first tick after resume comes 2 RUN cycles later.
3. In RUN with time_bcd = 16'h1234, pulse btn_lr -> lap_bcd = 16'h1234 and display_freeze = 1. Ticks continue. A second btn_lr releases the freeze and lap_bcd holds 16'h1234.
4. From PAUSE, pulse btn_lr -> a single-cycle count_clear pulse, lap_bcd = 0, state = 00. A further btn_lr in IDLE gives no count_clear.
5. Drive at_max = 1 in RUN -> the next tick is suppressed and state = 11. btn_ss is ignored. btn_lr clears and returns to IDLE.
6. Rise btn_ss and btn_lr on the same cycle in RUN -> state = PAUSE with no lap capture. Separately, pull rst low mid-RUN -> all outputs are 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: button conditioning, run/pause/lap/clear FSM,
// 1/100 s tick prescaler with saturation at 99.99 and lap snapshot register.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 1000000,
    parameter int DIV_W    = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_ss,
    input  logic        btn_lr,
    input  logic [15:0] time_bcd,
    input  logic        at_max,
    output logic        tick,
    output logic        count_clear,
    output logic        display_freeze,
    output logic [15:0] lap_bcd,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        LAP   = 2'b10,
        PAUSE = 2'b11
    } state_t;

    state_t             state_reg, state_next;
    logic [DIV_W-1:0]   presc_reg, presc_next;
    logic               tick_reg, tick_next;
    logic               clear_reg, clear_next;
    logic               freeze_reg, freeze_next;
    logic [15:0]        lap_reg, lap_next;
    logic [1:0]         fill_reg;
    logic [1:0]         btn_raw;
    logic [1:0]         pulse;
    logic               ss_p, lr_p;

    assign btn_raw = {btn_lr, btn_ss};

    // Counts the two cycles the synchronizers need to hold real button levels
    // after reset, so an arming decision never looks at the reset zeros.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_reg <= 2'd0;
        end else if (fill_reg != 2'd2) begin
            fill_reg <= fill_reg + 2'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic sync1_reg, sync2_reg, prev_reg, pulse_reg, armed_reg;

            // A button held through reset stays disarmed until it is seen low.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    prev_reg  <= 1'b0;
                    pulse_reg <= 1'b0;
                    armed_reg <= 1'b0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    prev_reg  <= sync2_reg;
                    pulse_reg <= sync2_reg & ~prev_reg & armed_reg;
                    if (fill_reg == 2'd2 && !sync2_reg) begin
                        armed_reg <= 1'b1;
                    end
                end
            end

            assign pulse[gi] = pulse_reg;
        end
    endgenerate

    assign ss_p = pulse[0];
    assign lr_p = pulse[1];

    logic running, wrap, sat;
    assign running = (state_reg == RUN) || (state_reg == LAP);
    assign wrap    = (presc_reg == DIV_W'(TICK_DIV - 1));
    assign sat     = running && wrap && at_max;

    always_comb begin
        state_next = state_reg;
        presc_next = presc_reg;
        tick_next  = running && wrap && !at_max;
        clear_next = 1'b0;
        lap_next   = lap_reg;
        if (running) begin
            presc_next = wrap ? '0 : presc_reg + DIV_W'(1);
        end
        case (state_reg)
            IDLE: begin
                if (ss_p) state_next = RUN;
            end
            RUN: begin
                if (sat || ss_p) begin
                    state_next = PAUSE;
                end else if (lr_p) begin
                    state_next = LAP;
                    lap_next   = time_bcd;
                end
            end
            LAP: begin
                if (sat || ss_p) state_next = PAUSE;
                else if (lr_p)   state_next = RUN;
            end
            PAUSE: begin
                // ss_p always shadows lr_p, even when at_max blocks the resume.
                if (ss_p) begin
                    if (!at_max) state_next = RUN;
                end else if (lr_p) begin
                    state_next = IDLE;
                    clear_next = 1'b1;
                    presc_next = '0;
                    lap_next   = 16'h0000;
                end
            end
            default: state_next = IDLE;
        endcase
        freeze_next = (state_next == LAP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            presc_reg  <= '0;
            tick_reg   <= 1'b0;
            clear_reg  <= 1'b0;
            freeze_reg <= 1'b0;
            lap_reg    <= 16'h0000;
        end else begin
            state_reg  <= state_next;
            presc_reg  <= presc_next;
            tick_reg   <= tick_next;
            clear_reg  <= clear_next;
            freeze_reg <= freeze_next;
            lap_reg    <= lap_next;
        end
    end

    assign tick           = tick_reg;
    assign count_clear    = clear_reg;
    assign display_freeze = freeze_reg;
    assign lap_bcd        = lap_reg;
    assign state          = state_reg;

endmodule
